// File: rtl/wb_intgen_mc.sv
// rtl/wb_intgen_mc.sv - Wishbone multi-channel programmable interrupt generator
// Optional shared tick prescaler enabled by defining INTGEN_PRESCALER_EN.
module wb_intgen_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int AW     = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [AW-1:0]     wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [NUM_CH-1:0] irq_o
);

    localparam int PRE_ADR = 2*NUM_CH + 2;

    logic [31:0]       adr;
    logic              req;
    logic              mapped;
    logic              wr;
    logic              rd;
    logic              sts_wr;
    logic              en_wr;
    logic              tick;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] armed;
    logic [NUM_CH-1:0] periodic;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] cnt_wr;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CNT_W-1:0]  rel [NUM_CH];
    logic              unused_dat;

    assign unused_dat = ^wb_dat_i;

`ifdef INTGEN_PRESCALER_EN
    logic [15:0] presc;
    logic [15:0] pcnt;
    logic        pre_wr;

    assign pre_wr = wr && (adr == 32'(PRE_ADR));
    assign tick   = (pcnt == presc);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc <= '0;
            pcnt  <= '0;
        end else if (pre_wr) begin
            presc <= wb_dat_i[15:0];
            pcnt  <= '0;
        end else begin
            pcnt <= tick ? 16'd0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        adr = 32'(wb_adr_i);
        req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
`ifdef INTGEN_PRESCALER_EN
        mapped = (adr <= 32'(PRE_ADR));
`else
        mapped = (adr < 32'(PRE_ADR));
`endif
        wr     = req & mapped & wb_we_i;
        rd     = req & mapped & ~wb_we_i;
        sts_wr = wr && (adr == 32'd0);
        en_wr  = wr && (adr == 32'd1);

        rdata = '0;
        if (adr == 32'd0) rdata[NUM_CH-1:0] = pending;
        if (adr == 32'd1) rdata[NUM_CH-1:0] = enable;
`ifdef INTGEN_PRESCALER_EN
        if (adr == 32'(PRE_ADR)) rdata[15:0] = presc;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_wr[ch]  = wr && (adr == 32'(2 + 2*ch));
            ctrl_wr[ch] = wr && (adr == 32'(3 + 2*ch));
            if (adr == 32'(2 + 2*ch)) rdata[CNT_W-1:0] = cnt[ch];
            if (adr == 32'(3 + 2*ch)) rdata[1:0] = {pulse[ch], periodic[ch]};
            // A COUNT write on the expiry edge overrides the expiry entirely.
            expire[ch] = armed[ch] & tick & (cnt[ch] == CNT_W'(1)) & ~cnt_wr[ch];
        end
    end

    always_comb begin
        irq_o = enable & ((pending & ~pulse) | (pulse_q & pulse));
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
            pending  <= '0;
            enable   <= '0;
            armed    <= '0;
            periodic <= '0;
            pulse    <= '0;
            pulse_q  <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch] <= '0;
                rel[ch] <= '0;
            end
        end else begin
            wb_ack_o <= req & mapped;
            wb_err_o <= req & ~mapped;
            wb_dat_o <= rd ? rdata : 32'd0;
            if (en_wr) enable <= wb_dat_i[NUM_CH-1:0];
            // Expiry set takes priority over a same-edge W1C.
            pending <= (pending & ~(sts_wr ? wb_dat_i[NUM_CH-1:0] : {NUM_CH{1'b0}})) | expire;
            pulse_q <= expire;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (ctrl_wr[ch]) begin
                    periodic[ch] <= wb_dat_i[0];
                    pulse[ch]    <= wb_dat_i[1];
                end
                if (cnt_wr[ch]) begin
                    rel[ch]   <= wb_dat_i[CNT_W-1:0];
                    cnt[ch]   <= wb_dat_i[CNT_W-1:0];
                    armed[ch] <= |wb_dat_i[CNT_W-1:0];
                end else if (armed[ch] && tick) begin
                    if (cnt[ch] == CNT_W'(1)) begin
                        if (periodic[ch]) begin
                            cnt[ch] <= rel[ch];
                        end else begin
                            cnt[ch]   <= '0;
                            armed[ch] <= 1'b0;
                        end
                    end else begin
                        cnt[ch] <= cnt[ch] - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
